// File: rtl/async_fifo_arb_pkg.sv
// Shared types and helpers for the async FIFO write-port burst arbiter.
package async_fifo_arb_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, BURST = 2'd2} arb_state_t;

  localparam int LEN_W_MAX = 16;

  // A zero-length request still moves one beat.
  function automatic logic [LEN_W_MAX-1:0] clamp_len(input logic [LEN_W_MAX-1:0] len);
    return (len == {LEN_W_MAX{1'b0}}) ? {{(LEN_W_MAX-1){1'b0}}, 1'b1} : len;
  endfunction

endpackage

// File: rtl/async_fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    valid
);
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] cand;
  logic          hit;

  // Scan from farthest to nearest so the nearest hit after 'last' wins.
  always_comb begin
    idx   = {IW{1'b0}};
    valid = 1'b0;
    cand  = {IW{1'b0}};
    hit   = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      cand  = IW'((int'(last) + k) % NREQ);
      hit   = req[cand];
      idx   = hit ? cand : idx;
      valid = valid | hit;
    end
  end

endmodule

// File: rtl/async_fifo_wr_arb.sv
// Round-robin burst arbiter for the write port of async_fifo_th; a burst
// starts only when the FIFO free space covers the whole burst.
module async_fifo_wr_arb
  import async_fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int AW   = 2
) (
  input  logic                  wr_clk,
  input  logic                  wr_reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*(AW+1)-1:0] req_len,
  input  logic [NREQ*W-1:0]     req_data,
  input  logic [NREQ-1:0]       req_vld,
  output logic [NREQ-1:0]       req_rdy,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       burst_done,
  input  logic [AW:0]           fifo_free,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [W-1:0]          fifo_wr_data,
  output logic                  ovf_err
);
  localparam int IW = $clog2(NREQ);
  localparam int LW = AW + 1;

  arb_state_t      state_r;
  logic [IW-1:0]   owner_r;
  logic [IW-1:0]   last_gnt_r;
  logic [LW-1:0]   len_q_r;
  logic [LW-1:0]   beat_cnt_r;
  logic [NREQ-1:0] gnt_r;
  logic [NREQ-1:0] burst_done_r;
  logic            ovf_err_r;

  logic [IW-1:0]   pick_idx_s;
  logic            pick_vld_s;
  logic            xfer_s;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req   (req),
    .last  (last_gnt_r),
    .idx   (pick_idx_s),
    .valid (pick_vld_s)
  );

  assign xfer_s = (state_r == BURST) && req_vld[owner_r];

  // Arbitration and burst sequencing.
  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      state_r      <= IDLE;
      owner_r      <= {IW{1'b0}};
      last_gnt_r   <= IW'(NREQ - 1);
      len_q_r      <= {LW{1'b0}};
      beat_cnt_r   <= {LW{1'b0}};
      gnt_r        <= {NREQ{1'b0}};
      burst_done_r <= {NREQ{1'b0}};
    end else begin
      burst_done_r <= {NREQ{1'b0}};
      case (state_r)
        IDLE: begin
          if (pick_vld_s) begin
            owner_r    <= pick_idx_s;
            last_gnt_r <= pick_idx_s;
            len_q_r    <= LW'(clamp_len(LEN_W_MAX'(req_len[int'(pick_idx_s)*LW +: LW])));
            beat_cnt_r <= {LW{1'b0}};
            gnt_r      <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
            state_r    <= WAIT;
          end else begin
            state_r    <= IDLE;
          end
        end
        // Free space only grows while we wait, so one check covers the burst.
        WAIT: begin
          if (fifo_free >= len_q_r) begin
            state_r <= BURST;
          end else begin
            state_r <= WAIT;
          end
        end
        BURST: begin
          if (xfer_s) begin
            if (beat_cnt_r == len_q_r - LW'(1)) begin
              state_r      <= IDLE;
              beat_cnt_r   <= {LW{1'b0}};
              gnt_r        <= {NREQ{1'b0}};
              burst_done_r <= {{(NREQ-1){1'b0}}, 1'b1} << owner_r;
            end else begin
              beat_cnt_r   <= beat_cnt_r + LW'(1);
            end
          end else begin
            state_r <= BURST;
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= {NREQ{1'b0}};
        end
      endcase
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      ovf_err_r <= 1'b0;
    end else if (fifo_wr_en && fifo_full) begin
      ovf_err_r <= 1'b1;
    end else begin
      ovf_err_r <= ovf_err_r;
    end
  end

  // Zero-latency beat path from the owner to the FIFO write port.
  always_comb begin
    req_rdy      = {NREQ{1'b0}};
    fifo_wr_en   = 1'b0;
    fifo_wr_data = {W{1'b0}};
    if (state_r == BURST) begin
      req_rdy[owner_r] = 1'b1;
      fifo_wr_en       = req_vld[owner_r];
      fifo_wr_data     = req_data[int'(owner_r)*W +: W];
    end else begin
      req_rdy      = {NREQ{1'b0}};
      fifo_wr_en   = 1'b0;
      fifo_wr_data = {W{1'b0}};
    end
  end

  assign gnt        = gnt_r;
  assign burst_done = burst_done_r;
  assign ovf_err    = ovf_err_r;

endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// Directed testbench for async_fifo_wr_arb with hand-computed expectations.
module tb_async_fifo_wr_arb;
  logic        wr_clk;
  logic        wr_reset_n;
  logic [3:0]  req;
  logic [11:0] req_len;
  logic [31:0] req_data;
  logic [3:0]  req_vld;
  logic [3:0]  req_rdy;
  logic [3:0]  gnt;
  logic [3:0]  burst_done;
  logic [2:0]  fifo_free;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        ovf_err;

  int tests = 0;
  int fails = 0;

  async_fifo_wr_arb #(.NREQ(4), .W(8), .AW(2)) dut (
    .wr_clk       (wr_clk),
    .wr_reset_n   (wr_reset_n),
    .req          (req),
    .req_len      (req_len),
    .req_data     (req_data),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .gnt          (gnt),
    .burst_done   (burst_done),
    .fifo_free    (fifo_free),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .ovf_err      (ovf_err)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  initial begin
    logic [5:0] vpat;
    int exp_i;
    vpat = 6'b111001; // gap pattern 1,0,0,1,1,1 read from bit 0 upward

    wr_reset_n = 1'b0;
    req = 4'h0; req_len = 12'h000; req_data = 32'h0; req_vld = 4'h0;
    fifo_free = 3'd0; fifo_full = 1'b0;
    #12;
    check("rst_gnt", gnt, 4'h0);
    check("rst_rdy", req_rdy, 4'h0);
    check("rst_wr_en", fifo_wr_en, 1'b0);
    check("rst_wr_data", fifo_wr_data, 8'h00);
    check("rst_done", burst_done, 4'h0);
    check("rst_ovf", ovf_err, 1'b0);

    // Single requester, len 3, free 4.
    req = 4'b0001; req_len = 12'h003; fifo_free = 3'd4; req_vld = 4'b0001; req_data = 32'h0000_00A0;
    wr_reset_n = 1'b1;
    tick();
    check("s1_gnt", gnt, 4'b0001);
    check("s1_wait_wr_en", fifo_wr_en, 1'b0);
    req = 4'b0000;
    tick();
    for (int b = 0; b < 3; b++) begin
      req_data = 32'h0000_00A0 + b;
      #1;
      check("s1_wr_en", fifo_wr_en, 1'b1);
      check("s1_wr_data", fifo_wr_data, 8'hA0 + b);
      check("s1_rdy", req_rdy, 4'b0001);
      check("s1_done_early", burst_done, 4'h0);
      tick();
    end
    check("s1_done", burst_done, 4'b0001);
    check("s1_idle_wr_en", fifo_wr_en, 1'b0);
    check("s1_idle_gnt", gnt, 4'h0);
    tick();
    check("s1_done_pulse", burst_done, 4'h0);

    // Round-robin from a fresh reset: order 0,1,2,3,0.
    wr_reset_n = 1'b0;
    #1;
    wr_reset_n = 1'b1;
    req = 4'b1111; req_len = 12'h249; req_vld = 4'b1111; req_data = 32'hD3D2_D1D0; fifo_free = 3'd4;
    for (int g = 0; g < 5; g++) begin
      exp_i = g % 4;
      tick();
      check("rr_gnt", gnt, 4'b0001 << exp_i);
      tick();
      check("rr_wr_en", fifo_wr_en, 1'b1);
      check("rr_wr_data", fifo_wr_data, 8'hD0 + exp_i);
      tick();
      check("rr_done", burst_done, 4'b0001 << exp_i);
    end
    req = 4'b0000;

    // Free-space wait then gapped burst on requester 1 (last grant was 0).
    req = 4'b0010; req_len = 12'h020; req_vld = 4'b0010; req_data = 32'h0000_5500; fifo_free = 3'd2;
    tick();
    check("fw_gnt", gnt, 4'b0010);
    req = 4'b0000;
    for (int w = 0; w < 3; w++) begin
      tick();
      check("fw_hold_gnt", gnt, 4'b0010);
      check("fw_hold_wr_en", fifo_wr_en, 1'b0);
      check("fw_hold_rdy", req_rdy, 4'h0);
    end
    fifo_free = 3'd4;
    tick();
    for (int c = 0; c < 6; c++) begin
      req_vld = {2'b00, vpat[c], 1'b0};
      #1;
      check("gap_wr_en", fifo_wr_en, vpat[c]);
      check("gap_rdy", req_rdy, 4'b0010);
      check("gap_wr_data", fifo_wr_data, 8'h55);
      tick();
      check("gap_done", burst_done, (c == 5) ? 4'b0010 : 4'b0000);
    end

    // Reset mid-burst on requester 2 after two beats.
    req = 4'b0100; req_len = 12'h100; req_vld = 4'b0100; req_data = 32'h0077_0000;
    tick();
    check("mr_gnt", gnt, 4'b0100);
    req = 4'b0000;
    tick();
    tick();
    tick();
    check("mr_mid_wr_en", fifo_wr_en, 1'b1);
    wr_reset_n = 1'b0;
    #1;
    check("mr_rst_gnt", gnt, 4'h0);
    check("mr_rst_wr_en", fifo_wr_en, 1'b0);
    check("mr_rst_rdy", req_rdy, 4'h0);
    check("mr_rst_wr_data", fifo_wr_data, 8'h00);
    check("mr_rst_done", burst_done, 4'h0);

    // After release requester 0 wins; len 0 acts as one beat; overflow flag.
    req = 4'b0101; req_len = 12'h000; req_vld = 4'b0001; req_data = 32'h0000_0099;
    wr_reset_n = 1'b1;
    tick();
    check("pr_gnt", gnt, 4'b0001);
    check("pr_done", burst_done, 4'h0);
    req = 4'b0000;
    tick();
    fifo_full = 1'b1;
    #1;
    check("l0_wr_en", fifo_wr_en, 1'b1);
    check("l0_wr_data", fifo_wr_data, 8'h99);
    check("ovf_before", ovf_err, 1'b0);
    tick();
    fifo_full = 1'b0;
    check("l0_done", burst_done, 4'b0001);
    check("l0_idle_wr_en", fifo_wr_en, 1'b0);
    check("ovf_set", ovf_err, 1'b1);
    tick();
    tick();
    check("ovf_sticky", ovf_err, 1'b1);
    check("l0_no_regrant", gnt, 4'h0);
    wr_reset_n = 1'b0;
    #1;
    check("ovf_cleared", ovf_err, 1'b0);
    wr_reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
